// File: rtl/jk_game_seq.sv
// Game-flow sequencer: title, play, level fade, win; frame-aligned on vsync rise.
// Optional pause overlay when JK_GAME_SEQ_PAUSE_EN is defined.
module jk_game_seq #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int FADE_FRAMES    = 15,
    parameter int WIN_LEVEL      = 3,
    parameter int TIME_MAX       = 5999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        key_space,
    input  logic        key_esc,
    input  logic [1:0]  level,
    output logic        ctl_hold,
    output logic        ctl_freeze,
    output logic [1:0]  screen,
    output logic [3:0]  fade_level,
    output logic [12:0] play_secs
);

    typedef enum logic [2:0] {
        S_TITLE = 3'd0,
        S_PLAY  = 3'd1,
        S_FADE  = 3'd2,
        S_WIN   = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    localparam logic [5:0]  FRAME_LAST = 6'(FRAMES_PER_SEC - 1);
    localparam logic [3:0]  FADE_LOAD  = 4'(FADE_FRAMES);
    localparam logic [1:0]  WIN_LVL    = 2'(WIN_LEVEL);
    localparam logic [12:0] SECS_MAX   = 13'(TIME_MAX);

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic [5:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  fade_cnt_q, fade_cnt_d;
    logic [1:0]  level_q, level_d;
    logic [12:0] play_secs_q, play_secs_d;
    logic        key_space_q, key_space_d;
    logic        vsync_q, vsync_d;
    logic        hold_q, hold_d;
    logic        freeze_q, freeze_d;
    logic [1:0]  screen_q, screen_d;
    logic [3:0]  fade_lvl_q, fade_lvl_d;

    logic press_space;
    logic frame_start;
    logic timer_run;

`ifdef JK_GAME_SEQ_PAUSE_EN
    logic key_esc_q, key_esc_d;
    logic press_esc;

    assign key_esc_d = key_esc;
    assign press_esc = key_esc & ~key_esc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_esc_q <= 1'b0;
        end else begin
            key_esc_q <= key_esc_d;
        end
    end
`else
    logic unused_esc;
    assign unused_esc = key_esc;
`endif

    assign key_space_d = key_space;
    assign vsync_d     = vsync;
    assign press_space = key_space & ~key_space_q;
    assign frame_start = vsync & ~vsync_q;
    assign timer_run   = frame_start &
                         ((state_q == S_PLAY) || (state_q == S_FADE));

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        fade_cnt_d  = fade_cnt_q;
        level_d     = level_q;
        play_secs_d = play_secs_q;
        hold_d      = 1'b1;
        freeze_d    = 1'b0;
        screen_d    = 2'd0;
        fade_lvl_d  = 4'd0;

        if (timer_run) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = 6'd0;
                if (play_secs_q < SECS_MAX) begin
                    play_secs_d = play_secs_q + 13'd1;
                end
            end else begin
                frame_cnt_d = frame_cnt_q + 6'd1;
            end
        end

        unique case (state_q)
            S_TITLE: begin
                if (frame_start && (pending_q || press_space)) begin
                    pending_d   = 1'b0;
                    play_secs_d = 13'd0;
                    frame_cnt_d = 6'd0;
                    level_d     = level;
                    state_d     = S_PLAY;
                end else if (press_space) begin
                    pending_d = 1'b1;
                end
            end
            S_PLAY: begin
                hold_d   = 1'b0;
                screen_d = 2'd1;
                if (level == WIN_LVL) begin
                    state_d = S_WIN;
                end else if (level != level_q) begin
                    level_d    = level;
                    fade_cnt_d = FADE_LOAD;
                    state_d    = S_FADE;
                end
`ifdef JK_GAME_SEQ_PAUSE_EN
                else if (press_esc) begin
                    pending_d = 1'b0;
                    state_d   = S_PAUSE;
                end
`endif
            end
            S_FADE: begin
                hold_d     = 1'b0;
                freeze_d   = 1'b1;
                screen_d   = 2'd2;
                fade_lvl_d = fade_cnt_q;
                if (level == WIN_LVL) begin
                    state_d = S_WIN;
                end else if (level != level_q) begin
                    level_d    = level;
                    fade_cnt_d = FADE_LOAD;
                end else if (frame_start) begin
                    // Leaving on the frame that reaches zero keeps the fade FADE_FRAMES long
                    if (fade_cnt_q <= 4'd1) begin
                        fade_cnt_d = 4'd0;
                        state_d    = S_PLAY;
                    end else begin
                        fade_cnt_d = fade_cnt_q - 4'd1;
                    end
                end
            end
            S_WIN: begin
                screen_d = 2'd3;
                if (frame_start && (pending_q || press_space)) begin
                    pending_d = 1'b0;
                    state_d   = S_TITLE;
                end else if (press_space) begin
                    pending_d = 1'b1;
                end
            end
`ifdef JK_GAME_SEQ_PAUSE_EN
            S_PAUSE: begin
                hold_d     = 1'b0;
                freeze_d   = 1'b1;
                screen_d   = 2'd3;
                fade_lvl_d = 4'd8;
                if (frame_start && (pending_q || press_esc)) begin
                    pending_d = 1'b0;
                    state_d   = S_PLAY;
                end else if (press_esc) begin
                    pending_d = 1'b1;
                end
            end
`endif
            default: begin
                pending_d = 1'b0;
                state_d   = S_TITLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_TITLE;
            pending_q   <= 1'b0;
            frame_cnt_q <= 6'd0;
            fade_cnt_q  <= 4'd0;
            level_q     <= 2'd0;
            play_secs_q <= 13'd0;
            key_space_q <= 1'b0;
            vsync_q     <= 1'b0;
            hold_q      <= 1'b1;
            freeze_q    <= 1'b0;
            screen_q    <= 2'd0;
            fade_lvl_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            fade_cnt_q  <= fade_cnt_d;
            level_q     <= level_d;
            play_secs_q <= play_secs_d;
            key_space_q <= key_space_d;
            vsync_q     <= vsync_d;
            hold_q      <= hold_d;
            freeze_q    <= freeze_d;
            screen_q    <= screen_d;
            fade_lvl_q  <= fade_lvl_d;
        end
    end

    assign ctl_hold   = hold_q;
    assign ctl_freeze = freeze_q;
    assign screen     = screen_q;
    assign fade_level = fade_lvl_q;
    assign play_secs  = play_secs_q;

endmodule
